// File: rtl/case_branch_pkg.sv
// ---------------------------------------------------------------------------
// case_branch_pkg
// Shared types and constants for the case-branch arbiter slice.
//   branch_e  : branch code carried on out_branch and used to pick a counter
//   state_e   : dispatch slot state (IDLE = empty, HOLD = dispatch on output)
//   SEL_ONE / SEL_TWO : selector values that decode to BR_ONE / BR_TWO
//   NUM_BRANCH : number of hit counters (one per branch code)
// ---------------------------------------------------------------------------
package case_branch_pkg;

   typedef enum logic [1:0] {
      BR_DEFAULT = 2'd0,
      BR_ONE     = 2'd1,
      BR_TWO     = 2'd2
   } branch_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int SEL_ONE    = 1;
   localparam int SEL_TWO    = 2;
   localparam int NUM_BRANCH = 3;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a combinational one-hot grant.
// Ports:
//   clk   : clock, pointer updates on the rising edge
//   rst_n : asynchronous active-low reset, pointer returns to requester 0
//   req   : per-requester request vector
//   en    : grant enable; when low no grant is issued and the pointer holds
//   gnt   : one-hot grant (all zero when en is low or no request is up)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_nextPtr;
   logic [IDX_W-1:0] w_idx;
   logic             w_found;

   // Scan requesters starting at the pointer (the one after the last winner)
   // and wrapping around; the first active request wins.  The pointer that
   // would follow this winner is computed alongside so the register only
   // has to load it.
   always_comb begin
      gnt       = '0;
      w_nextPtr = r_ptr;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = IDX_W'((int'(r_ptr) + k) % NREQ);
         if (en && !w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            w_found    = 1'b1;
            w_nextPtr  = IDX_W'((int'(w_idx) + 1) % NREQ);
         end
      end
   end

   // The pointer only moves when a grant is actually issued, so a stalled
   // slot does not rotate priority away from the waiting requesters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= w_nextPtr;
      end
   end

endmodule

// File: rtl/case_branch_arbiter.sv
// ---------------------------------------------------------------------------
// case_branch_arbiter
// Arbitrates NREQ requesters into a single registered dispatch slot, decodes
// the winner's selector into a branch code and counts accepted dispatches
// per branch in saturating hit counters.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   req, sel    : per-requester request and flattened selectors
//   gnt         : one-hot grant (combinational)
//   out_valid / out_ready : dispatch handshake
//   out_branch, out_src   : registered branch code and winning index
//   clr         : synchronous clear of all hit counters
//   rd_branch, rd_data    : combinational counter read port
// ---------------------------------------------------------------------------
module case_branch_arbiter
   import case_branch_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int SEL_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*SEL_W-1:0]   sel,
   output logic [NREQ-1:0]         gnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_branch,
   output logic [$clog2(NREQ)-1:0] out_src,
   input  logic                    clr,
   input  logic [1:0]              rd_branch,
   output logic [CNT_W-1:0]        rd_data
);

   localparam int SRC_W = $clog2(NREQ);

   state_e            r_state;
   state_e            w_stateNext;
   branch_e           r_outBranch;
   logic [SRC_W-1:0]  r_outSrc;
   logic [CNT_W-1:0]  r_hitCnt [NUM_BRANCH];

   logic              w_slotFree;
   logic              w_arbEn;
   logic              w_grant;
   logic              w_handshake;
   logic [NREQ-1:0]   w_gnt;
   logic [SEL_W-1:0]  w_gntSel;
   logic [SRC_W-1:0]  w_gntSrc;
   branch_e           w_gntBranch;

   // Grants are suppressed while reset is held so nothing downstream sees a
   // grant that can never be registered.
   assign w_arbEn = w_slotFree & rst_n;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rrArbiter (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .en    (w_arbEn),
      .gnt   (w_gnt)
   );

   assign gnt         = w_gnt;
   assign w_grant     = |w_gnt;
   assign w_handshake = out_valid & out_ready;
   assign out_branch  = r_outBranch;
   assign out_src     = r_outSrc;

   // Pick the winning requester's selector and index out of the flattened
   // bus; the grant is one-hot so at most one iteration matches.
   always_comb begin
      w_gntSel = '0;
      w_gntSrc = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_gntSel = sel[i*SEL_W +: SEL_W];
            w_gntSrc = SRC_W'(i);
         end
      end
   end

   // Only the exact values 1 and 2 select a named branch; everything else,
   // zero and negative selectors included, falls to the default branch.
   always_comb begin
      if (w_gntSel == SEL_W'(SEL_ONE)) begin
         w_gntBranch = BR_ONE;
      end else if (w_gntSel == SEL_W'(SEL_TWO)) begin
         w_gntBranch = BR_TWO;
      end else begin
         w_gntBranch = BR_DEFAULT;
      end
   end

   // Slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A grant always (re)fills the slot.  Without a grant the slot keeps its
   // dispatch while downstream stalls and empties once it is accepted.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_stateNext = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_stateNext = w_grant ? ST_HOLD : ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // The slot is free when empty or when its current content is being
   // accepted this cycle, which lets back-to-back dispatches run at full rate.
   always_comb begin
      out_valid  = (r_state == ST_HOLD);
      w_slotFree = (r_state == ST_IDLE) || out_ready;
   end

   // Dispatch payload is captured only on a grant, so it stays put during a
   // stall and keeps its last value after the slot drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outBranch <= BR_DEFAULT;
         r_outSrc    <= '0;
      end else if (w_grant) begin
         r_outBranch <= w_gntBranch;
         r_outSrc    <= w_gntSrc;
      end
   end

   // Hit counters count accepted dispatches per branch and stick at all-ones.
   // A clear takes priority, dropping any handshake in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BRANCH; b++) begin
            r_hitCnt[b] <= '0;
         end
      end else if (clr) begin
         for (int b = 0; b < NUM_BRANCH; b++) begin
            r_hitCnt[b] <= '0;
         end
      end else if (w_handshake) begin
         for (int b = 0; b < NUM_BRANCH; b++) begin
            if ((r_outBranch == 2'(b)) && (r_hitCnt[b] != '1)) begin
               r_hitCnt[b] <= r_hitCnt[b] + CNT_W'(1);
            end
         end
      end
   end

   // Counter read port; code 3 has no counter behind it and reads as zero.
   always_comb begin
      case (rd_branch)
         2'd0:    rd_data = r_hitCnt[0];
         2'd1:    rd_data = r_hitCnt[1];
         2'd2:    rd_data = r_hitCnt[2];
         default: rd_data = '0;
      endcase
   end

endmodule
